// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong ball engine: FSM encoding, screen
// size defaults and the two-digit BCD score representation.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_POINT = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam int SCREEN_W_DEFAULT = 640;
    localparam int SCREEN_H_DEFAULT = 480;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } bcd2_t;

    // Saturating two-digit BCD increment: 09 -> 10, 99 holds.
    function automatic bcd2_t bcd2_sat_inc(input bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.tens == 4'd9 && v.ones == 4'd9) begin
            r = v;
        end else if (v.ones == 4'd9) begin
            r.ones = 4'd0;
            r.tens = v.tens + 4'd1;
        end else begin
            r.ones = v.ones + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit saturating BCD score counter with synchronous clear and an
// increment enable; one instance per player.
module bcd_score_counter
    import pong_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_inc,
    output bcd_t o_tens,
    output bcd_t o_ones
);

    bcd2_t r_count;

    // NOTE: sequential state is always written with <= so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= bcd2_sat_inc(r_count);
        end
    end

    assign o_tens = r_count.tens;
    assign o_ones = r_count.ones;

endmodule

// File: rtl/ball_engine.sv
// Pong ball engine: serve timer, ball motion with wall/paddle collisions,
// goal detection, BCD scoring and game-over handling, all advanced by tick.
module ball_engine
    import pong_pkg::*;
#(
    parameter int SCREEN_W    = SCREEN_W_DEFAULT,
    parameter int SCREEN_H    = SCREEN_H_DEFAULT,
    parameter int BALL_W      = 8,
    parameter int GOAL_MARGIN = 7,
    parameter int DX_INIT     = 2,
    parameter int DX_MAX      = 6,
    parameter int WIN_SCORE   = 11,
    parameter int SERVE_DELAY = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic [5:0] wall_width,
    input  logic [5:0] paddle_width,
    input  logic [8:0] paddle_length,
    input  logic [8:0] paddle_l_y,
    input  logic [8:0] paddle_r_y,
    input  logic [2:0] rand_in,
    output logic [9:0] pos_x,
    output logic [8:0] pos_y,
    output logic       dir_x,
    output logic [1:0] state,
    output logic [3:0] score_l_tens,
    output logic [3:0] score_l_ones,
    output logic [3:0] score_r_tens,
    output logic [3:0] score_r_ones,
    output logic       point,
    output logic       game_over
);

    typedef logic signed [10:0] s11_t;

    localparam int   SCW       = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam logic [SCW-1:0] SERVE_LAST = SCW'(SERVE_DELAY - 1);
    localparam logic [9:0] CENTER_X  = 10'(SCREEN_W / 2 - BALL_W / 2);
    localparam logic [8:0] CENTER_Y  = 9'(SCREEN_H / 2 - BALL_W / 2);
    localparam logic [9:0] MAX_X     = 10'(SCREEN_W - BALL_W);
    localparam logic [8:0] MAX_Y     = 9'(SCREEN_H - BALL_W);
    localparam logic [3:0] DX_INIT_V = 4'(DX_INIT);
    localparam logic [3:0] DX_MAX_V  = 4'(DX_MAX);
    localparam bcd_t       WIN_TENS  = 4'(WIN_SCORE / 10);
    localparam bcd_t       WIN_ONES  = 4'(WIN_SCORE % 10);

    localparam s11_t S_BALL_W  = s11_t'(BALL_W);
    localparam s11_t S_GOAL_LO = s11_t'(GOAL_MARGIN);
    localparam s11_t S_GOAL_HI = s11_t'(SCREEN_W - GOAL_MARGIN);
    localparam s11_t S_RIGHT   = s11_t'(SCREEN_W - 1);
    localparam s11_t S_BOTTOM  = s11_t'(SCREEN_H - 1);
    localparam s11_t S_MAX_X   = s11_t'(SCREEN_W - BALL_W);
    localparam s11_t S_MAX_Y   = s11_t'(SCREEN_H - BALL_W);

    state_t         r_state;
    logic [SCW-1:0] r_serve_cnt;
    logic [9:0]     r_pos_x;
    logic [8:0]     r_pos_y;
    logic [3:0]     r_dx;
    logic [2:0]     r_dy;
    logic           r_dir_x;
    logic           r_dir_y;
    logic           r_point;
    logic           r_right_scored;

    // Every geometric test runs on sign-extended 11-bit values so that
    // sums and differences near the screen edges cannot wrap.
    s11_t w_px, w_py, w_pw, w_ww, w_plen, w_ply, w_pry, w_dx, w_dy;
    assign w_px   = s11_t'({1'b0, r_pos_x});
    assign w_py   = s11_t'({2'b0, r_pos_y});
    assign w_pw   = s11_t'({5'b0, paddle_width});
    assign w_ww   = s11_t'({5'b0, wall_width});
    assign w_plen = s11_t'({2'b0, paddle_length});
    assign w_ply  = s11_t'({2'b0, paddle_l_y});
    assign w_pry  = s11_t'({2'b0, paddle_r_y});
    assign w_dx   = s11_t'({7'b0, r_dx});
    assign w_dy   = s11_t'({8'b0, r_dy});

    logic w_goal_r, w_goal_l, w_ovl_l, w_ovl_r, w_hit_l, w_hit_r;
    assign w_goal_r = (w_px <= S_GOAL_LO);
    assign w_goal_l = (w_px + S_BALL_W >= S_GOAL_HI);
    assign w_ovl_l  = (w_py + S_BALL_W > w_ply) && (w_py < w_ply + w_plen);
    assign w_ovl_r  = (w_py + S_BALL_W > w_pry) && (w_py < w_pry + w_plen);
    assign w_hit_l  = r_dir_x && (w_px < w_pw) && w_ovl_l;
    assign w_hit_r  = !r_dir_x && (w_px + S_BALL_W > S_RIGHT - w_pw) && w_ovl_r;

    logic       w_dir_x_next, w_dir_y_next;
    logic [3:0] w_dx_next;
    s11_t       w_nx, w_ny;
    logic [9:0] w_next_x;
    logic [8:0] w_next_y;

    // NOTE: each always_comb output is assigned a default before any branch
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_dir_x_next = r_dir_x;
        w_dx_next    = r_dx;
        w_dir_y_next = r_dir_y;
        if (w_hit_l || w_hit_r) begin
            w_dir_x_next = w_hit_r;
            w_dx_next    = (r_dx >= DX_MAX_V) ? DX_MAX_V : r_dx + 4'd1;
        end
        if (w_py < w_ww) begin
            w_dir_y_next = 1'b0;
        end else if (w_py + S_BALL_W > S_BOTTOM - w_ww) begin
            w_dir_y_next = 1'b1;
        end

        w_nx = w_dir_x_next ? w_px - s11_t'({7'b0, w_dx_next}) : w_px + s11_t'({7'b0, w_dx_next});
        w_ny = w_dir_y_next ? w_py - w_dy : w_py + w_dy;

        if (w_nx < s11_t'(0))  w_next_x = '0;
        else if (w_nx > S_MAX_X) w_next_x = MAX_X;
        else                   w_next_x = w_nx[9:0];

        if (w_ny < s11_t'(0))  w_next_y = '0;
        else if (w_ny > S_MAX_Y) w_next_y = MAX_Y;
        else                   w_next_y = w_ny[8:0];
    end

    logic w_play_tick, w_inc_l, w_inc_r, w_clear, w_win;
    assign w_play_tick = (r_state == ST_PLAY) && tick;
    assign w_inc_r     = w_play_tick && w_goal_r;
    assign w_inc_l     = w_play_tick && w_goal_l && !w_goal_r;
    assign w_clear     = (r_state == ST_OVER) && start;
    assign w_win       = ({score_l_tens, score_l_ones} == {WIN_TENS, WIN_ONES}) ||
                         ({score_r_tens, score_r_ones} == {WIN_TENS, WIN_ONES});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_SERVE;
            r_serve_cnt    <= '0;
            r_pos_x        <= CENTER_X;
            r_pos_y        <= CENTER_Y;
            r_dx           <= DX_INIT_V;
            r_dy           <= 3'd1;
            r_dir_x        <= 1'b0;
            r_dir_y        <= 1'b0;
            r_point        <= 1'b0;
            r_right_scored <= 1'b0;
        end else begin
            r_point <= 1'b0;
            case (r_state)
                ST_SERVE: begin
                    r_pos_x <= CENTER_X;
                    r_pos_y <= CENTER_Y;
                    r_dx    <= DX_INIT_V;
                    if (tick) begin
                        if (r_serve_cnt == SERVE_LAST) begin
                            r_serve_cnt <= '0;
                            r_dy        <= {rand_in[2:1], 1'b1};
                            r_dir_y     <= rand_in[0];
                            r_state     <= ST_PLAY;
                        end else begin
                            r_serve_cnt <= r_serve_cnt + 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        if (w_goal_r || w_goal_l) begin
                            r_point        <= 1'b1;
                            r_right_scored <= w_goal_r;
                            r_state        <= ST_POINT;
                        end else begin
                            r_dir_x <= w_dir_x_next;
                            r_dx    <= w_dx_next;
                            r_dir_y <= w_dir_y_next;
                            r_pos_x <= w_next_x;
                            r_pos_y <= w_next_y;
                        end
                    end
                end
                ST_POINT: begin
                    if (w_win) begin
                        r_state <= ST_OVER;
                    end else begin
                        // Next serve heads toward the player who conceded.
                        r_state     <= ST_SERVE;
                        r_dir_x     <= r_right_scored;
                        r_serve_cnt <= '0;
                        r_pos_x     <= CENTER_X;
                        r_pos_y     <= CENTER_Y;
                        r_dx        <= DX_INIT_V;
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        r_state     <= ST_SERVE;
                        r_dir_x     <= 1'b0;
                        r_serve_cnt <= '0;
                        r_pos_x     <= CENTER_X;
                        r_pos_y     <= CENTER_Y;
                        r_dx        <= DX_INIT_V;
                    end
                end
                default: r_state <= ST_SERVE;
            endcase
        end
    end

    bcd_score_counter u_score_l (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_clear),
        .i_inc   (w_inc_l),
        .o_tens  (score_l_tens),
        .o_ones  (score_l_ones)
    );

    bcd_score_counter u_score_r (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_clear),
        .i_inc   (w_inc_r),
        .o_tens  (score_r_tens),
        .o_ones  (score_r_ones)
    );

    assign pos_x     = r_pos_x;
    assign pos_y     = r_pos_y;
    assign dir_x     = r_dir_x;
    assign state     = r_state;
    assign point     = r_point;
    assign game_over = (r_state == ST_OVER);

endmodule

// File: doc/ball_engine.md
BALL_ENGINE -- requirements
Module: ball_engine

Interface
REQ-001 SCREEN_W, 640, playfield width in pixels; x ports are 10 bits.
REQ-002 SCREEN_H, 480, playfield height in pixels; y ports are 9 bits.
REQ-003 BALL_W, 8, ball edge length in pixels.
REQ-004 GOAL_MARGIN, 7, goal-line distance from each side edge.
REQ-005 DX_INIT, 2, horizontal speed at serve, in pixels per tick.
REQ-006 DX_MAX, 6, horizontal speed cap, in pixels per tick.
REQ-007 WIN_SCORE, 11, decimal score that ends the game (1..99).
REQ-008 SERVE_DELAY, 60, number of ticks the ball is held at centre before launch.
REQ-009 clk  in  1  single system clock; the design has one clock and reset is synchronous and active-high.
REQ-010 reset  in  1  synchronous, active-high reset.
REQ-011 tick  in  1  one-cycle frame strobe; all motion and timing advance only on cycles with tick=1.
REQ-012 start  in  1  level input; leaves OVER.
REQ-013 wall_width, paddle_width  in  6 each  top/bottom wall thickness and left/right paddle thickness.
REQ-014 paddle_length  in  9  paddle height.
REQ-015 paddle_l_y, paddle_r_y  in  9 each  paddle top edges.
REQ-016 rand_in  in  3  random bits, sampled at serve.
REQ-017 pos_x  out  10  ball upper-left x; pos_y  out  9  ball upper-left y.
REQ-018 dir_x  out  1  horizontal direction: 0 = +x, 1 = -x.
REQ-019 state  out  2  current FSM state.
REQ-020 score_l_tens, score_l_ones, score_r_tens, score_r_ones  out  4 each  BCD scores.
REQ-021 point  out  1  one-cycle pulse on each goal.
REQ-022 game_over  out  1  high while in OVER.

Function
REQ-023 FSM states: SERVE=0, PLAY=1, POINT=2, OVER=3; all transitions occur on clk edges.
REQ-024 SERVE holds ball at centre:
- pos_x = SCREEN_W/2 - BALL_W/2
- pos_y = SCREEN_H/2 - BALL_W/2
- dx = DX_INIT
- dy = {rand_in[2:1],1}, so dy is odd and nonzero
- dir_y = rand_in[0]
REQ-025 SERVE counts ticks; on the SERVE_DELAY-th tick it latches dy and dir_y from rand_in and enters PLAY.
REQ-026 PLAY, per tick, evaluates in priority order: goal, paddle, wall, move.
REQ-027 Goal conditions:
- pos_x <= GOAL_MARGIN: right player scores.
- pos_x + BALL_W >= SCREEN_W - GOAL_MARGIN: left player scores.
REQ-028 On a goal, the engine increments the scorer's BCD count, pulses point, and enters POINT; the ball does not move on that tick.
REQ-029 Left-paddle hit:
- Condition: dir_x=1, pos_x < paddle_width, and the ball overlaps [paddle_l_y, paddle_l_y + paddle_length).
- Response: dir_x <= 0; dx <= min(dx+1, DX_MAX).
REQ-030 Right-paddle hit:
- Condition: dir_x=0, pos_x + BALL_W > SCREEN_W - 1 - paddle_width, and the ball overlaps the right paddle.
- Response: dir_x <= 1; dx <= min(dx+1, DX_MAX).
- The engine ignores a paddle hit while the ball is moving away from that paddle.
REQ-031 Wall bounce:
- pos_y < wall_width sets dir_y=0.
- pos_y + BALL_W > SCREEN_H - 1 - wall_width sets dir_y=1.
REQ-032 Movement:
- pos_x moves by dx and pos_y by dy, in the current (post-collision) direction.
- pos_x is clamped to [0, SCREEN_W - BALL_W] and pos_y to [0, SCREEN_H - BALL_W].
- All arithmetic uses 11-bit signed intermediates; wrap-around is forbidden.
REQ-033 POINT lasts one cycle:
- If either score equals WIN_SCORE, the engine enters OVER.
- Otherwise it enters SERVE and sets dir_x toward the conceding player (right scored gives dir_x=1).
REQ-034 BCD increment: ones 9→0 carries into tens; tens and ones saturate at 9,9.
REQ-035 OVER freezes the ball and scores; start=1 clears all scores, sets dir_x=0, and enters SERVE.
REQ-036 In states other than OVER, start is ignored; tick is ignored in POINT and OVER.

Reset
REQ-037 reset=1 overrides all other inputs, including simultaneous tick and start.
REQ-038 Reset values:
- state=SERVE, serve counter=0
- pos = centre
- dx=DX_INIT, dy=1, dir_x=0, dir_y=0
- all scores 0, point=0, game_over=0
REQ-039 Reset mid-PLAY or mid-POINT takes effect on the next edge; no pending score survives it.

Structure
REQ-040 Package pong_pkg holds:
- the state enumeration
- default screen constants (640, 480)
- BCD digit typedef
REQ-041 One sub-module, bcd_score_counter: a two-digit saturating BCD counter with synchronous clear and increment enable, instantiated once per player.

Verification
REQ-042 Reset, then 60 ticks → state goes SERVE→PLAY on the 60th tick; pos = (316,236), dir_x=0.
REQ-043 Ball moving -x at pos_x=4 with a paddle miss, then a tick → score_r_ones=1, point is a single-cycle pulse, and SERVE follows with dir_x=1.
REQ-044 dx=6, ball overlapping the left paddle while moving -x, then a tick → dir_x=0, dx stays 6; a second overlapping tick while moving +x causes no reversal.
REQ-045 Left score at 0,9, then a goal → tens=1, ones=0; with WIN_SCORE=11, a further goal → OVER and game_over=1; start then clears scores and returns to SERVE.
REQ-046 reset asserted in the same cycle as a goal tick → scores stay 0, no point pulse, state=SERVE.
